// File: rtl/t01_pkg.sv
// Shared types for the t01 memory arbiter: access width encoding and the
// alignment rule used when a data request is accepted.
package t01_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } data_width;

  // Any encoding other than BYTE/HALFWORD is handled as a full word.
  function automatic logic is_misaligned(input logic [1:0] addr, input data_width width);
    case (width)
      BYTE:     return 1'b0;
      HALFWORD: return addr[0];
      default:  return addr != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/t01_lane_align.sv
// Byte-lane steering between a 32-bit word bus and a narrow data port:
// lane enables, write data shifted into lane, read data right-justified.
module t01_lane_align
  import t01_pkg::*;
(
  input  logic [1:0]  addr,
  input  data_width   width,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_al
);

  logic [31:0] rdata_sh;

  always_comb begin
    rdata_sh = rdata >> {addr, 3'b000};
    wdata_sh = wdata << {addr, 3'b000};
    case (width)
      BYTE: begin
        sel      = 4'b0001 << addr;
        rdata_al = {24'h0, rdata_sh[7:0]};
      end
      HALFWORD: begin
        sel      = 4'b0011 << addr;
        rdata_al = {16'h0, rdata_sh[15:0]};
      end
      default: begin
        sel      = 4'b1111;
        rdata_al = rdata_sh;
      end
    endcase
  end

endmodule

// File: rtl/t01_mem_arbiter.sv
// Arbitrates a data port and an instruction-fetch port onto one word bus,
// with a one-deep pending slot for write pulses and a bus timeout.
module t01_mem_arbiter
  import t01_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        DataRead,
  input  logic        DataWrite,
  input  logic [31:0] address_DM,
  input  logic [31:0] writedata_o,
  input  data_width   datawidth,
  output logic [31:0] data_i,
  output logic        dhit,
  input  logic        InstrRead,
  input  logic [31:0] instr_address,
  output logic [31:0] instr,
  output logic        ihit,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  // Bus handshake: a strobe (bus_read or bus_write, never both) is held with
  // stable bus_addr/bus_sel/bus_wdata until the cycle bus_ack is sampled high;
  // bus_rdata is valid only in that cycle. Ack outside a bus state is ignored.

  typedef enum logic [1:0] {IDLE = 2'd0, DBUS = 2'd1, IBUS = 2'd2, RESP = 2'd3} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t      state_q, next_state;
  logic [31:0] d_addr_q, d_wdata_q;
  data_width   d_width_q;
  logic        d_write_q;
  logic [31:2] i_addr_q;
  logic        pend_valid_q;
  logic [31:0] pend_addr_q, pend_wdata_q;
  data_width   pend_width_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] resp_data_q;
  logic        resp_is_data_q, resp_err_q;

  logic        take_pend, take_data, take_instr, pend_set;
  logic        resp_load, resp_is_data_d, resp_err_d;
  logic [31:0] resp_data_d;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_rdata;

  t01_lane_align u_lane (
    .addr     (d_addr_q[1:0]),
    .width    (d_width_q),
    .wdata    (d_wdata_q),
    .rdata    (bus_rdata),
    .sel      (lane_sel),
    .wdata_sh (lane_wdata),
    .rdata_al (lane_rdata)
  );

  // A write pulse that cannot be accepted directly this cycle is parked.
  assign pend_set = DataWrite && !(state_q == IDLE && !pend_valid_q);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state     = state_q;
    take_pend      = 1'b0;
    take_data      = 1'b0;
    take_instr     = 1'b0;
    resp_load      = 1'b0;
    resp_data_d    = 32'h0;
    resp_is_data_d = 1'b0;
    resp_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid_q || DataRead || DataWrite) begin
          take_pend      = pend_valid_q;
          take_data      = !pend_valid_q;
          resp_is_data_d = 1'b1;
          if (pend_valid_q ? is_misaligned(pend_addr_q[1:0], pend_width_q)
                           : is_misaligned(address_DM[1:0], datawidth)) begin
            next_state = RESP;
            resp_load  = 1'b1;
            resp_err_d = 1'b1;
          end else begin
            next_state = DBUS;
          end
        end else if (InstrRead) begin
          take_instr = 1'b1;
          next_state = IBUS;
        end
      end
      DBUS, IBUS: begin
        resp_is_data_d = (state_q == DBUS);
        if (bus_ack) begin
          next_state  = RESP;
          resp_load   = 1'b1;
          resp_data_d = (state_q == DBUS) ? lane_rdata : bus_rdata;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          next_state = RESP;
          resp_load  = 1'b1;
          resp_err_d = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      d_addr_q       <= 32'h0;
      d_wdata_q      <= 32'h0;
      d_width_q      <= BYTE;
      d_write_q      <= 1'b0;
      i_addr_q       <= 30'h0;
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= 32'h0;
      pend_wdata_q   <= 32'h0;
      pend_width_q   <= BYTE;
      cnt_q          <= '0;
      resp_data_q    <= 32'h0;
      resp_is_data_q <= 1'b0;
      resp_err_q     <= 1'b0;
    end else begin
      if (take_pend) begin
        d_addr_q  <= pend_addr_q;
        d_wdata_q <= pend_wdata_q;
        d_width_q <= pend_width_q;
        d_write_q <= 1'b1;
      end else if (take_data) begin
        d_addr_q  <= address_DM;
        d_wdata_q <= writedata_o;
        d_width_q <= datawidth;
        d_write_q <= DataWrite;
      end
      if (take_instr) i_addr_q <= instr_address[31:2];

      if (pend_set) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= address_DM;
        pend_wdata_q <= writedata_o;
        pend_width_q <= datawidth;
      end else if (take_pend) begin
        pend_valid_q <= 1'b0;
      end

      if ((state_q == DBUS || state_q == IBUS) && next_state == state_q) cnt_q <= cnt_q + 1'b1;
      else                                                                cnt_q <= '0;

      if (resp_load) begin
        resp_data_q    <= resp_data_d;
        resp_is_data_q <= resp_is_data_d;
        resp_err_q     <= resp_err_d;
      end
    end
  end

  always_comb begin
    bus_read  = (state_q == IBUS) || (state_q == DBUS && !d_write_q);
    bus_write = (state_q == DBUS) && d_write_q;
    bus_addr  = 32'h0;
    bus_sel   = 4'h0;
    bus_wdata = 32'h0;
    if (state_q == DBUS) begin
      bus_addr = {d_addr_q[31:2], 2'b00};
      bus_sel  = lane_sel;
      if (d_write_q) bus_wdata = lane_wdata;
    end else if (state_q == IBUS) begin
      bus_addr = {i_addr_q, 2'b00};
      bus_sel  = 4'hF;
    end
    dhit    = (state_q == RESP) && resp_is_data_q;
    ihit    = (state_q == RESP) && !resp_is_data_q;
    bus_err = (state_q == RESP) && resp_err_q;
    data_i  = dhit ? resp_data_q : 32'h0;
    instr   = ihit ? resp_data_q : 32'h0;
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_t01_mem_arbiter.sv
// Self-checking bench for t01_mem_arbiter: directed scenarios plus random
// data/fetch traffic checked against an arithmetic reference model.
module tb_t01_mem_arbiter;
  import t01_pkg::*;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        nRST;
  logic        DataRead, DataWrite, InstrRead, bus_ack;
  logic [31:0] address_DM, writedata_o, instr_address, bus_rdata;
  data_width   datawidth;
  logic [31:0] data_i, instr, bus_addr, bus_wdata;
  logic        dhit, ihit, bus_read, bus_write, bus_err;
  logic [3:0]  bus_sel;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  t01_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nRST(nRST),
    .DataRead(DataRead), .DataWrite(DataWrite), .address_DM(address_DM),
    .writedata_o(writedata_o), .datawidth(datawidth), .data_i(data_i), .dhit(dhit),
    .InstrRead(InstrRead), .instr_address(instr_address), .instr(instr), .ihit(ihit),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes and the rules derived from it
  function automatic int nbytes(input data_width w);
    case (w)
      BYTE:     return 1;
      HALFWORD: return 2;
      default:  return 4;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [31:0] a, input data_width w);
    return (a % nbytes(w)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [31:0] a, input data_width w);
    int n = nbytes(w);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] a, input logic [31:0] wd);
    return 32'(64'(wd) << (8 * (a % 4)));
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a, input data_width w, input logic [31:0] rd);
    logic [63:0] mask = (64'd1 << (8 * nbytes(w))) - 64'd1;
    return 32'((64'(rd) >> (8 * (a % 4))) & mask);
  endfunction

  // Bus slave: called at a negedge while a strobe should be up; acks after dly cycles
  task automatic serve_bus(input bit exp_rd, input bit exp_wr, input logic [31:0] exp_addr,
                           input logic [3:0] exp_sel, input logic [31:0] exp_wdata,
                           input int dly, input logic [31:0] rd);
    for (int i = 0; i <= dly; i++) begin
      check_eq("bus_read", 32'(bus_read), 32'(exp_rd));
      check_eq("bus_write", 32'(bus_write), 32'(exp_wr));
      check_eq("bus_addr", bus_addr, exp_addr);
      check_eq("bus_sel", 32'(bus_sel), 32'(exp_sel));
      if (exp_wr) check_eq("bus_wdata", bus_wdata, exp_wdata);
      if (i == dly) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
      @(negedge clk);
    end
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
  endtask

  // Called at the negedge of the response cycle; leaves the bench at the following idle negedge
  task automatic expect_hit(input bit is_data, input bit exp_err, input bit chk_data);
    logic [31:0] exp;
    check_eq(is_data ? "dhit" : "ihit", 32'(is_data ? dhit : ihit), 32'd1);
    check_eq(is_data ? "ihit_quiet" : "dhit_quiet", 32'(is_data ? ihit : dhit), 32'd0);
    check_eq("bus_err", 32'(bus_err), 32'(exp_err));
    check_eq("strobes_in_resp", 32'({bus_read, bus_write}), 32'd0);
    if (chk_data) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else begin
        exp = exp_q.pop_front();
        check_eq(is_data ? "data_i" : "instr", is_data ? data_i : instr, exp);
      end
    end
    DataRead = 1'b0;
    @(negedge clk);
    check_eq("hit_pulse_len", 32'({dhit, ihit, bus_err}), 32'd0);
  endtask

  task automatic do_data(input bit wr, input logic [31:0] a, input data_width w,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly);
    address_DM  = a;
    datawidth   = w;
    writedata_o = wd;
    if (wr) DataWrite = 1'b1;
    else    DataRead  = 1'b1;
    @(negedge clk);
    DataWrite = 1'b0;
    if (model_misaligned(a, w)) begin
      check_eq("misalign_no_strobe", 32'({bus_read, bus_write}), 32'd0);
      exp_q.push_back(32'h0);
      expect_hit(1'b1, 1'b1, 1'b1);
    end else begin
      if (!wr) exp_q.push_back(model_rdata(a, w, rd));
      serve_bus(!wr, wr, {a[31:2], 2'b00}, model_sel(a, w), model_wdata(a, wd), dly, rd);
      expect_hit(1'b1, 1'b0, !wr);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] rd, input int dly, input bit drop);
    InstrRead     = 1'b1;
    instr_address = a;
    @(negedge clk);
    if (drop) InstrRead = 1'b0;
    exp_q.push_back(rd);
    serve_bus(1'b1, 1'b0, a, 4'hF, 32'h0, dly, rd);
    InstrRead = 1'b0;
    expect_hit(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int cyc;
    logic [31:0] a, rd;

    nRST = 1'b0; DataRead = 1'b0; DataWrite = 1'b0; InstrRead = 1'b0; bus_ack = 1'b0;
    address_DM = 32'h0; writedata_o = 32'h0; datawidth = BYTE; instr_address = 32'h0;
    bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("rst_strobes", 32'({bus_read, bus_write, bus_err, dhit, ihit}), 32'd0);
    nRST = 1'b1;
    @(negedge clk);
    check_eq("post_rst_outputs", 32'({bus_read, bus_write, bus_err, dhit, ihit, bus_sel}), 32'd0);
    check_eq("post_rst_addr", bus_addr, 32'h0);
    check_eq("post_rst_data", data_i | instr, 32'h0);

    // Byte read at top lane, halfword write at upper half
    do_data(1'b0, 32'h0000_1003, BYTE, 32'h0, 32'hAB00_0000, 3);
    do_data(1'b1, 32'h0000_2002, HALFWORD, 32'h0000_1234, 32'h0, 2);

    // Data and fetch requested together: data first, then fetch
    DataRead = 1'b1; InstrRead = 1'b1;
    address_DM = 32'h0000_0500; datawidth = WORD; instr_address = 32'h0000_0600;
    @(negedge clk);
    exp_q.push_back(32'hCAFE_F00D);
    serve_bus(1'b1, 1'b0, 32'h0000_0500, 4'hF, 32'h0, 1, 32'hCAFE_F00D);
    expect_hit(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    InstrRead = 1'b0;
    exp_q.push_back(32'h1357_9BDF);
    serve_bus(1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'h0, 0, 32'h1357_9BDF);
    expect_hit(1'b0, 1'b0, 1'b1);

    // Misaligned word read
    do_data(1'b0, 32'h0000_3001, WORD, 32'h0, 32'hFFFF_FFFF, 0);

    // Write pulse during a fetch is parked, then served before the next fetch
    InstrRead = 1'b1; instr_address = 32'h0000_8000;
    @(negedge clk);
    address_DM = 32'h0000_4001; datawidth = BYTE; writedata_o = 32'h0000_005A; DataWrite = 1'b1;
    @(negedge clk);
    DataWrite = 1'b0; address_DM = 32'hDEAD_BEEF; writedata_o = 32'hFFFF_FFFF; datawidth = WORD;
    exp_q.push_back(32'h1111_2222);
    serve_bus(1'b1, 1'b0, 32'h0000_8000, 4'hF, 32'h0, 2, 32'h1111_2222);
    expect_hit(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    serve_bus(1'b0, 1'b1, 32'h0000_4000, 4'b0010, 32'h0000_5A00, 1, 32'h0);
    expect_hit(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    InstrRead = 1'b0;
    exp_q.push_back(32'h3333_4444);
    serve_bus(1'b1, 1'b0, 32'h0000_8000, 4'hF, 32'h0, 0, 32'h3333_4444);
    expect_hit(1'b0, 1'b0, 1'b1);

    // Fetch with no ack: timeout, InstrRead dropped after acceptance
    InstrRead = 1'b1; instr_address = 32'h0000_9000;
    @(negedge clk);
    InstrRead = 1'b0;
    cyc = 0;
    while (bus_read === 1'b1 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    check_eq("timeout_strobe_cycles", 32'(cyc), 32'(TO));
    exp_q.push_back(32'h0);
    expect_hit(1'b0, 1'b1, 1'b1);

    // Reset in the middle of a data bus cycle; late ack must be ignored
    DataRead = 1'b1; address_DM = 32'h0000_0700; datawidth = WORD;
    @(negedge clk);
    check_eq("pre_rst_strobe", 32'(bus_read), 32'd1);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    check_eq("rst_drops_strobe", 32'({bus_read, bus_write}), 32'd0);
    check_eq("rst_state_mid", 32'(dbg_state), 32'd0);
    @(negedge clk);
    nRST = 1'b1; DataRead = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("late_ack_no_hit", 32'({dhit, ihit, bus_read, bus_write, bus_err}), 32'd0);
      @(negedge clk);
    end

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      a  = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 2))
        0: do_data(1'b0, a, data_width'($urandom_range(0, 2)), 32'h0, rd, $urandom_range(0, 4));
        1: do_data(1'b1, a, data_width'($urandom_range(0, 2)), $urandom, rd, $urandom_range(0, 4));
        default: begin
          a[1:0] = 2'b00;
          do_fetch(a, rd, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end
      endcase
    end

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t01_mem_arbiter.md
T01_MEM_ARBITER -- requirements
Module: t01_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting for bus_ack before abort.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 DataRead  in  1  data read request, level, held until dhit.
REQ-005 DataWrite  in  1  data write request, one-cycle pulse.
REQ-006 address_DM  in  32  data byte address.
REQ-007 writedata_o  in  32  write data, value in low lanes.
REQ-008 datawidth  in  data_width  BYTE/HALFWORD/WORD.
REQ-009 data_i  out  32  read data, right-justified, valid while dhit=1.
REQ-010 dhit  out  1  data transaction complete, one-cycle pulse.
REQ-011 InstrRead  in  1  instruction fetch request, level.
REQ-012 instr_address  in  32  fetch address, word aligned.
REQ-013 instr  out  32  fetched word, valid while ihit=1.
REQ-014 ihit  out  1  fetch complete, one-cycle pulse.
REQ-015 bus_addr  out  32  word-aligned bus address (addr[1:0]=0).
REQ-016 bus_wdata  out  32  lane-shifted write data.
REQ-017 bus_sel  out  4  byte-lane enables.
REQ-018 bus_read / bus_write  out  1 each  request strobes, held until bus_ack.
REQ-019 bus_rdata  in  32  read data, valid with bus_ack; bus_ack  in  1  one-cycle completion.
REQ-020 bus_err  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-021 States SHALL be IDLE, DBUS, IBUS, RESP.
REQ-022 IDLE: DataRead or DataWrite -> latch address, data, width, direction -> DBUS; else InstrRead -> latch instr_address -> IBUS; data SHALL win when both are requested.
REQ-023 A DataWrite pulse arriving outside IDLE SHALL be held pending and served on the next IDLE, ahead of any fetch.
REQ-024 DBUS/IBUS: bus_read or bus_write plus bus_addr, bus_sel, bus_wdata SHALL stay stable and asserted until bus_ack; on bus_ack, capture bus_rdata -> RESP.
REQ-025 RESP (exactly 1 cycle): dhit or ihit=1 with registered data_i or instr; no new request accepted; -> IDLE. Latency from bus_ack to hit SHALL be 1 cycle.
REQ-026 bus_sel: BYTE=4'b0001<<addr[1:0]; HALFWORD=4'b0011<<addr[1:0]; WORD=4'b1111; bus_wdata=writedata_o<<(8*addr[1:0]).
REQ-027 data_i SHALL be bus_rdata>>(8*addr[1:0]), with zeros above the selected width; sign extension is not performed here.
REQ-028 Misaligned data access (HALFWORD with addr[0]=1, WORD with addr[1:0]!=0): no bus cycle; bus_err and dhit SHALL both pulse 1 cycle after acceptance, data_i=0.
REQ-029 A cycle counter SHALL run in DBUS/IBUS; at TIMEOUT_CYCLES without bus_ack, drop strobes, pulse bus_err, and go to RESP with data 0.
REQ-030 A fetch in progress SHALL complete even if InstrRead falls; ihit still pulses.
REQ-031 bus_read and bus_write SHALL never both be 1.

Reset
REQ-032 nRST low SHALL asynchronously force state IDLE, abort any bus cycle, and clear all outputs, the pending write, latches, and the counter to 0.
REQ-033 Reset mid-transaction SHALL drop the strobes immediately; a bus_ack arriving after reset SHALL be ignored.

Structure
REQ-034 data_width (BYTE, HALFWORD, WORD) SHALL live in shared package t01_pkg; the state enum stays local.
REQ-035 Lane select and shift logic SHALL be combinational sub-module t01_lane_align (inputs addr[1:0], width, wdata, rdata; outputs sel, shifted wdata, aligned rdata).

Verification
REQ-036 BYTE read, addr 0x1003, bus_rdata 0xAB000000, ack after 3 cycles -> bus_sel 4'b1000, bus_addr 0x1000, data_i 0x000000AB, dhit 1 cycle after ack.
REQ-037 HALFWORD write 0x1234 to 0x2002 -> bus_sel 4'b1100, bus_wdata 0x12340000, bus_write held until ack, then dhit.
REQ-038 DataRead and InstrRead in the same cycle -> data transaction first, then fetch; ihit follows dhit.
REQ-039 WORD read at 0x3001 -> no strobe, bus_err and dhit pulse together, data_i 0.
REQ-040 Fetch with bus_ack never asserted -> strobe dropped after 255 cycles, bus_err and ihit pulse, instr 0.
REQ-041 nRST asserted during DBUS -> strobes 0 immediately; a late bus_ack produces no hit.
